// File: rtl/carregador_instrucoes_pkg.sv
// carregador_pkg: constants and types shared by the program loader and the
// instruction RAM slot map.
//   SLOT_SIZE  - words per slot
//   NUM_SLOTS  - number of valid slots (0..NUM_SLOTS-1)
//   estado_t   - loader FSM states
//   SLOT_BASE  - base word address of every slot
//   slot_base  - slot index -> base address (0 for an out-of-range slot)
package carregador_pkg;

    localparam int SLOT_SIZE = 1000;
    localparam int NUM_SLOTS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FIM   = 2'd2,
        FALHA = 2'd3
    } estado_t;

    localparam logic [31:0] SLOT_BASE [NUM_SLOTS] = '{
        32'd0, 32'd1000, 32'd2000, 32'd3000, 32'd4000, 32'd5000, 32'd6000
    };

    function automatic logic [31:0] slot_base(input int s);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (s == i) b = SLOT_BASE[i];
        return b;
    endfunction

endpackage

// File: rtl/carregador_instrucoes.sv
// carregador_instrucoes: loads a program image into one SLOT_SIZE-word slot of
// instruction RAM from a valid/ready word stream.
// Ports:
//   clock_i, reset_i        - clock, async active-high reset
//   start_i, slot_i,
//   length_i                - load request (sampled only in IDLE)
//   abort_i                 - cancel an active load
//   in_data_i, in_valid_i,
//   in_ready_o              - word stream handshake (in_ready combinational)
//   we_o, endereco_escrita_o,
//   data_o                  - registered RAM write port, 1 cycle after handshake
//   busy_o                  - high while loading
//   done_o                  - one-cycle pulse at the end of any load attempt
//   erro_o                  - sticky error, cleared by the next accepted start
//   palavras_escritas_o     - words accepted in the current/last load
module carregador_instrucoes
    import carregador_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SLOT_BITS  = 3,
    parameter int LEN_BITS   = 10
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [SLOT_BITS-1:0]  slot_i,
    input  logic [LEN_BITS-1:0]   length_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] endereco_escrita_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  erro_o,
    output logic [LEN_BITS-1:0]   palavras_escritas_o
);

    estado_t               state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_BITS-1:0]   len_q;
    logic [LEN_BITS-1:0]   count_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  erro_q;
    logic                  req_bad;

    // The length check is what keeps every write inside the slot.
    assign req_bad = (slot_i >= SLOT_BITS'(NUM_SLOTS)) ||
                     (length_i == '0) ||
                     (length_i > LEN_BITS'(SLOT_SIZE));

    assign in_ready_o = (state_q == LOAD) && !abort_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        count_q <= '0;
                        if (req_bad) begin
                            // Clear-then-set collapses to a plain set, so erro
                            // is already visible alongside the done pulse.
                            erro_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= FALHA;
                        end else begin
                            erro_q  <= 1'b0;
                            base_q  <= ADDR_WIDTH'(slot_base(int'(slot_i)));
                            len_q   <= length_i;
                            busy_q  <= 1'b1;
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        erro_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIM;
                    end else if (in_valid_i) begin
                        we_q    <= 1'b1;
                        addr_q  <= base_q + ADDR_WIDTH'(count_q);
                        data_q  <= in_data_i;
                        count_q <= count_q + 1'b1;
                        // Last word: its write lands in the FIM cycle.
                        if (count_q == len_q - 1'b1) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIM;
                        end
                    end
                end
                FIM:     state_q <= IDLE;
                FALHA:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign we_o                = we_q;
    assign endereco_escrita_o  = addr_q;
    assign data_o              = data_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign erro_o              = erro_q;
    assign palavras_escritas_o = count_q;

endmodule

// File: tb/tb_carregador_instrucoes.sv
module tb_carregador_instrucoes;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [2:0]  slot_i;
    logic [9:0]  length_i;
    logic        abort_i;
    logic [31:0] in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        we_o;
    logic [31:0] endereco_escrita_o;
    logic [31:0] data_o;
    logic        busy_o;
    logic        done_o;
    logic        erro_o;
    logic [9:0]  palavras_escritas_o;

    int total = 0;
    int bad   = 0;

    carregador_instrucoes dut (
        .clock_i            (clock_i),
        .reset_i            (reset_i),
        .start_i            (start_i),
        .slot_i             (slot_i),
        .length_i           (length_i),
        .abort_i            (abort_i),
        .in_data_i          (in_data_i),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .we_o               (we_o),
        .endereco_escrita_o (endereco_escrita_o),
        .data_o             (data_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .erro_o             (erro_o),
        .palavras_escritas_o(palavras_escritas_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    // Reference: a valid request writes word k of the stream to slot*1000+k,
    // one cycle after it is accepted; the load ends after len words or abort.
    // vmode: 0 = valid always, 1 = valid toggling, 2 = random valid.
    task automatic run_load(input int slot, input int len, input int vmode,
                            input int abort_after, input int restart_at);
        int          k = 0;
        int          cyc = 0;
        bit          acc_prev = 1'b0;
        bit          ab = 1'b0;
        bit          fin = 1'b0;
        bit          v, a;
        logic [31:0] d, base, addr_prev, dat_prev;
        bit          req_bad;
        req_bad = (slot >= 7) || (len == 0) || (len > 1000);
        base = 32'(slot * 1000);
        addr_prev = '0;
        dat_prev = '0;
        start_i = 1'b1; slot_i = 3'(slot); length_i = 10'(len);
        step();
        start_i = 1'b0; slot_i = 3'($urandom); length_i = 10'($urandom);
        if (req_bad) begin
            chk(32'(done_o), 1, "bad_done");
            chk(32'(erro_o), 1, "bad_erro");
            chk(32'(we_o), 0, "bad_we");
            chk(32'(busy_o), 0, "bad_busy");
            chk(32'(palavras_escritas_o), 0, "bad_count");
            step();
            chk(32'(done_o), 0, "bad_done_once");
            chk(32'(erro_o), 1, "bad_erro_sticky");
            return;
        end
        chk(32'(erro_o), 0, "erro_clr");
        while (!fin && cyc < 3000) begin
            chk(32'(busy_o), 1, "busy");
            chk(32'(done_o), 0, "done_early");
            chk(32'(we_o), 32'(acc_prev), "we");
            if (acc_prev) begin
                chk(endereco_escrita_o, addr_prev, "addr");
                chk(data_o, dat_prev, "data");
            end
            chk(32'(palavras_escritas_o), 32'(k), "count");
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = $urandom;
            a = (k == abort_after);
            in_valid_i = v; in_data_i = d; abort_i = a;
            if (cyc == restart_at) begin
                start_i = 1'b1; slot_i = 3'd3; length_i = 10'd5;
            end
            #1;
            chk(32'(in_ready_o), 32'(!a), "in_ready");
            acc_prev = v && !a;
            if (acc_prev) begin
                addr_prev = base + 32'(k);
                dat_prev = d;
                k++;
            end
            if (a) ab = 1'b1;
            if (a || k == len) fin = 1'b1;
            step();
            in_valid_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
            cyc++;
        end
        chk(32'(fin), 1, "load_timeout");
        chk(32'(done_o), 1, "done");
        chk(32'(busy_o), 0, "busy_end");
        chk(32'(we_o), 32'(acc_prev), "we_last");
        if (acc_prev) begin
            chk(endereco_escrita_o, addr_prev, "addr_last");
            chk(data_o, dat_prev, "data_last");
        end
        chk(32'(erro_o), 32'(ab), "erro_end");
        chk(32'(palavras_escritas_o), 32'(k), "count_end");
        chk(32'(in_ready_o), 0, "ready_fim");
        step();
        chk(32'(done_o), 0, "done_once");
        chk(32'(we_o), 0, "we_idle");
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; slot_i = '0; length_i = '0;
        abort_i = 1'b0; in_data_i = '0; in_valid_i = 1'b0;
        #1;
        chk(32'(we_o), 0, "rst_we");
        chk(endereco_escrita_o, 0, "rst_addr");
        chk(data_o, 0, "rst_data");
        chk(32'(busy_o), 0, "rst_busy");
        chk(32'(done_o), 0, "rst_done");
        chk(32'(erro_o), 0, "rst_erro");
        chk(32'(palavras_escritas_o), 0, "rst_count");
        chk(32'(in_ready_o), 0, "rst_ready");
        step(); step();
        reset_i = 1'b0;
        step();

        run_load(2, 3, 0, -1, -1);
        run_load(0, 4, 1, -1, -1);
        run_load(7, 5, 0, -1, -1);
        run_load(6, 1000, 0, -1, -1);
        run_load(1, 10, 0, 4, -1);
        run_load(4, 6, 2, -1, 2);
        run_load(3, 0, 0, -1, -1);
        run_load(5, 1001, 0, -1, -1);
        run_load(5, 1000, 2, -1, -1);

        // in_valid outside LOAD is never accepted
        in_valid_i = 1'b1; in_data_i = 32'hDEAD_BEEF;
        #1;
        chk(32'(in_ready_o), 0, "idle_ready");
        step();
        chk(32'(we_o), 0, "idle_we");
        in_valid_i = 1'b0;

        // Reset in the cycle right after a handshake
        start_i = 1'b1; slot_i = 3'd5; length_i = 10'd10;
        step();
        start_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h1234_5678;
        step();
        in_valid_i = 1'b0;
        chk(32'(we_o), 1, "pre_rst_we");
        chk(endereco_escrita_o, 5000, "pre_rst_addr");
        reset_i = 1'b1;
        #1;
        chk(32'(we_o), 0, "mid_rst_we");
        chk(endereco_escrita_o, 0, "mid_rst_addr");
        chk(32'(busy_o), 0, "mid_rst_busy");
        chk(32'(palavras_escritas_o), 0, "mid_rst_count");
        chk(32'(in_ready_o), 0, "mid_rst_ready");
        step();
        reset_i = 1'b0;
        step();
        chk(32'(busy_o), 0, "post_rst_idle");
        run_load(0, 5, 2, -1, -1);

        // Random requests, including out-of-range ones
        for (int i = 0; i < 8; i++) begin
            int s, l, ab;
            s  = int'($urandom_range(0, 7));
            l  = (i == 3) ? 0 : int'($urandom_range(1, 12));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_load(s, l, 2, ab, int'($urandom_range(0, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
